inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction queue entries; legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 redirect  input  1  branch/jump taken this cycle; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-007 mem_req  output  1  instruction-memory read request, registered.
REQ-008 mem_addr  output  32  read address, registered, word-aligned.
REQ-009 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-010 mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-011 inst_valid  output  1  queue head holds an instruction.
REQ-012 inst  output  32  queue-head instruction, fed to the datapath.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst_ready  input  1  datapath consumes the head this cycle.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (request outstanding, data kept), DROP (request outstanding, data discarded).
REQ-016 Internal fetch_pc holds the next address to request; it increments by 4 per accepted word, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-017 At most one request is outstanding at any time.
REQ-018 "Room" = occupancy after this cycle's pop is less than DEPTH, with one slot reserved for any outstanding request.
REQ-019 IDLE: when room exists and redirect=0, move to WAIT and assert mem_req=1 with mem_addr=fetch_pc on the next cycle.
REQ-020 WAIT: mem_req and mem_addr hold stable until the cycle in which mem_ack=1.
REQ-021 WAIT + mem_ack + no redirect: push {fetch_pc, mem_rdata} and set fetch_pc += 4.
REQ-021a If room remains after that push, stay in WAIT with mem_addr set to the new fetch_pc (back-to-back, no bubble).
REQ-021b Otherwise drop mem_req and go to IDLE.
REQ-022 WAIT + redirect without mem_ack: flush the queue, set fetch_pc=redirect_pc, go to DROP; mem_req and mem_addr keep the old request.
REQ-023 WAIT + redirect + mem_ack in the same cycle: discard mem_rdata, flush, set fetch_pc=redirect_pc, go to IDLE.
REQ-024 DROP: on mem_ack, discard data and go to IDLE; a further redirect in DROP only updates fetch_pc.
REQ-025 IDLE + redirect: flush, set fetch_pc=redirect_pc, stay in IDLE, issue on the next cycle.
REQ-026 Pop occurs when inst_valid & inst_ready; push and pop in the same cycle are both honoured and occupancy is unchanged.
REQ-027 Redirect overrides push and pop in the same cycle; a pop is not counted as a consumption.
REQ-028 inst_valid = occupancy>0; inst and inst_pc are 32'h0 whenever inst_valid=0.
REQ-029 Queue full: no request issued; inst_ready=0 while empty has no effect.
REQ-030 Latency: a word acknowledged at edge N appears on inst/inst_valid after edge N (next cycle), including when the queue was empty.

Reset
REQ-031 rst=1 immediately forces the following, regardless of any in-flight memory response:
- state=IDLE, fetch_pc=RESET_PC, queue empty;
- mem_req=0, mem_addr=0;
- inst_valid=0, inst=0, inst_pc=0.
REQ-032 An ack for a request issued before reset is ignored; the first request is issued one cycle after rst deasserts.

Structure
REQ-033 Shared package fetch_pkg holds: fetch_state_t (IDLE, WAIT, DROP), INST_W=32, PC_INC=32'd4.
REQ-034 The queue is a sub-module fetch_queue (DEPTH-entry, 64-bit {pc, inst} FIFO) with push, pop, flush, count, and head outputs.

Verification
REQ-035 Reset release, mem_ack 1 cycle after every request, inst_ready=1 -> mem_addr 0,4,8,C; inst_pc 0,4,8,C on consecutive valid cycles.
REQ-036 inst_ready=0, memory always acks -> exactly DEPTH words queued; mem_req=0 afterwards; raising inst_ready resumes fetching at 4*DEPTH.
REQ-037 Redirect to 32'h100 while the request for 32'h8 is outstanding -> mem_addr stays 8 until ack; that word is dropped; next request is 32'h100; inst_pc 8 never appears.
REQ-038 Redirect to 32'h40 in the same cycle as mem_ack -> data discarded, queue empty next cycle, next mem_addr=32'h40.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 rst asserted mid-WAIT with a late mem_ack -> outputs zero immediately, no push, refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit and its queue.
//   fetch_state_t : fetch FSM state encoding (IDLE, WAIT, DROP)
//   INST_W        : instruction / address width
//   ENTRY_W       : width of one queue entry {pc, inst}
//   PC_INC        : fetch address step per accepted word
//   word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int ENTRY_W = 2 * INST_W;

    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] pc);
        return {pc[INST_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry circular FIFO holding {pc, inst} pairs for the fetch unit.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : {pc, inst} entry
//   pop_i         : drop the head entry (caller guarantees count_o > 0)
//   flush_i       : empty the queue; overrides push and pop
//   count_o       : current occupancy
//   head_o        : head entry (undefined contents while empty)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [ENTRY_W-1:0]           push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [ENTRY_W-1:0]           head_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset: the head is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Sequential instruction prefetcher: issues one word read at a time, queues
// returned words with their address, and flushes/refetches on redirect.
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | no request outstanding
//   WAIT  | request outstanding, returned data kept
//   DROP  | request outstanding, returned data discarded
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   redirect, redirect_pc  : flush and refetch from redirect_pc
//   mem_req, mem_addr      : registered read request / word address
//   mem_ack, mem_rdata     : read response
//   inst_valid, inst,      : queue head (zero while empty)
//   inst_pc
//   inst_ready             : datapath consumes the head this cycle
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  pc_plus;

    logic               push, pop, flush;
    logic [CNT_W-1:0]   count, occ_after_pop;
    logic [ENTRY_W-1:0] head;
    logic               room_idle, room_after_push;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({fetch_pc_q, mem_rdata}),
        .pop_i       (pop),
        .flush_i     (flush),
        .count_o     (count),
        .head_o      (head)
    );

    assign inst_valid = (count != '0);
    // A redirect flushes the queue, so a simultaneous handshake is not a pop.
    assign pop           = inst_valid & inst_ready & ~redirect;
    assign occ_after_pop = count - CNT_W'(pop);
    // Issuing from IDLE reserves one slot for the new request; staying in
    // WAIT after a push needs one slot beyond the word just pushed.
    assign room_idle       = (occ_after_pop < DEPTH_C);
    assign room_after_push = (occ_after_pop < DEPTH_M1);
    assign pc_plus         = fetch_pc_q + PC_INC;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                end else if (room_idle) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus;
                    if (room_after_push) begin
                        mem_addr_d = pc_plus;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = word_align(redirect_pc);
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= word_align(RESET_PC);
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign inst     = inst_valid ? head[INST_W-1:0]       : '0;
    assign inst_pc  = inst_valid ? head[ENTRY_W-1:INST_W] : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench: a vector table with hand-computed outputs drives the default
// instance (DEPTH=2, RESET_PC=0); hand-written sequences cover address wrap
// (second instance, RESET_PC=FFFF_FFF8, DEPTH=4) and reset during a fetch.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_ack;
    logic [31:0] w_mem_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .mem_req     (w_mem_req),
        .mem_addr    (w_mem_addr),
        .mem_ack     (w_mem_ack),
        .mem_rdata   (w_mem_rdata),
        .inst_valid  (w_inst_valid),
        .inst        (w_inst),
        .inst_pc     (w_inst_pc),
        .inst_ready  (w_inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic a, input logic [31:0] d, input logic rdy,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r;      v.redirect = rd; v.redirect_pc = rpc;
        v.ack = a;      v.rdata = d;     v.ready = rdy;
        v.e_req = er;   v.e_addr = ea;   v.e_valid = ev;
        v.e_inst = ei;  v.e_pc = ep;
        vq.push_back(v);
    endtask

    task automatic check(input string name,
                         input logic g_req, input logic [31:0] g_addr,
                         input logic g_v, input logic [31:0] g_inst,
                         input logic [31:0] g_pc,
                         input logic e_req, input logic [31:0] e_addr,
                         input logic e_v, input logic [31:0] e_inst,
                         input logic [31:0] e_pc);
        n_checks++;
        if ({g_req, g_addr, g_v, g_inst, g_pc} !== {e_req, e_addr, e_v, e_inst, e_pc}) begin
            n_fail++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b inst=%h pc=%h, want req=%0b addr=%h valid=%0b inst=%h pc=%h",
                     name, g_req, g_addr, g_v, g_inst, g_pc, e_req, e_addr, e_v, e_inst, e_pc);
        end
    endtask

    task automatic chk_main(input string name, input logic er, input logic [31:0] ea,
                            input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        check(name, mem_req, mem_addr, inst_valid, inst, inst_pc, er, ea, ev, ei, ep);
    endtask

    task automatic chk_wrap(input string name, input logic er, input logic [31:0] ea,
                            input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        check(name, w_mem_req, w_mem_addr, w_inst_valid, w_inst, w_inst_pc, er, ea, ev, ei, ep);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        w_redirect = 1'b0; w_redirect_pc = '0; w_mem_ack = 1'b0;
        w_mem_rdata = '0; w_inst_ready = 1'b0;

        //   rst red rpc           ack rdata          rdy  req addr          v  inst           pc
        // sequential fetch with a consumer always ready
        add(1, 0, 32'h0,         0, 32'h0,          0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          1,   1, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'h1000_0000,  1,   1, 32'h4,         1, 32'h1000_0000, 32'h0);
        add(0, 0, 32'h0,         1, 32'h1000_0001,  1,   1, 32'h8,         1, 32'h1000_0001, 32'h4);
        add(0, 0, 32'h0,         1, 32'h1000_0002,  1,   1, 32'hC,         1, 32'h1000_0002, 32'h8);
        add(0, 0, 32'h0,         1, 32'h1000_0003,  1,   1, 32'h10,        1, 32'h1000_0003, 32'hC);
        add(0, 0, 32'h0,         0, 32'h0,          1,   1, 32'h10,        0, 32'h0,         32'h0);
        // consumer stalls: queue fills to DEPTH, requests stop, resume on pop
        add(0, 0, 32'h0,         1, 32'h1000_0004,  0,   1, 32'h14,        1, 32'h1000_0004, 32'h10);
        add(0, 0, 32'h0,         1, 32'h1000_0005,  0,   0, 32'h14,        1, 32'h1000_0004, 32'h10);
        add(0, 0, 32'h0,         0, 32'h0,          0,   0, 32'h14,        1, 32'h1000_0004, 32'h10);
        add(0, 0, 32'h0,         1, 32'hEEEE_EEEE,  0,   0, 32'h14,        1, 32'h1000_0004, 32'h10);
        add(0, 0, 32'h0,         0, 32'h0,          1,   1, 32'h18,        1, 32'h1000_0005, 32'h14);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h18,        1, 32'h1000_0005, 32'h14);
        // redirect while a request is outstanding: old request held, word dropped
        add(0, 1, 32'h100,       0, 32'h0,          0,   1, 32'h18,        0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h18,        0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'hDEAD_BEEF,  1,   0, 32'h18,        0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h100,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'h1000_0006,  0,   1, 32'h104,       1, 32'h1000_0006, 32'h100);
        // redirect coinciding with ack
        add(0, 1, 32'h40,        1, 32'hBAD0_0000,  0,   0, 32'h104,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h40,        0, 32'h0,         32'h0);
        // second redirect while dropping updates the target only
        add(0, 1, 32'h200,       0, 32'h0,          0,   1, 32'h40,        0, 32'h0,         32'h0);
        add(0, 1, 32'h300,       0, 32'h0,          0,   1, 32'h40,        0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'hBAD0_0001,  0,   0, 32'h40,        0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h300,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'h1000_0007,  0,   1, 32'h304,       1, 32'h1000_0007, 32'h300);
        add(0, 0, 32'h0,         1, 32'h1000_0008,  0,   0, 32'h304,       1, 32'h1000_0007, 32'h300);
        // redirect in IDLE with a full queue and a ready consumer
        add(0, 1, 32'h500,       0, 32'h0,          1,   0, 32'h304,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h500,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 32'h1000_0009,  0,   1, 32'h504,       1, 32'h1000_0009, 32'h500);
        add(0, 0, 32'h0,         0, 32'h0,          0,   1, 32'h504,       1, 32'h1000_0009, 32'h500);

        for (int i = 0; i < vq.size(); i++) begin
            rst         = vq[i].rst;
            redirect    = vq[i].redirect;
            redirect_pc = vq[i].redirect_pc;
            mem_ack     = vq[i].ack;
            mem_rdata   = vq[i].rdata;
            inst_ready  = vq[i].ready;
            step();
            chk_main($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr,
                     vq[i].e_valid, vq[i].e_inst, vq[i].e_pc);
        end

        // Wrap instance: has been waiting on its first request since reset.
        chk_wrap("wrap_first_req", 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0);
        w_mem_ack = 1'b1;
        w_mem_rdata = 32'h0000_0007;
        step();
        chk_wrap("wrap_fffc", 1, 32'hFFFF_FFFC, 1, 32'h0000_0007, 32'hFFFF_FFF8);
        w_mem_rdata = 32'h0000_0003;
        step();
        chk_wrap("wrap_zero", 1, 32'h0000_0000, 1, 32'h0000_0007, 32'hFFFF_FFF8);
        w_mem_rdata = 32'hFFFF_FFFF;
        step();
        chk_wrap("wrap_four", 1, 32'h0000_0004, 1, 32'h0000_0007, 32'hFFFF_FFF8);
        w_mem_rdata = 32'hFFFF_FFFB;
        step();
        chk_wrap("wrap_full", 0, 32'h0000_0004, 1, 32'h0000_0007, 32'hFFFF_FFF8);
        step();
        chk_wrap("wrap_full_hold", 0, 32'h0000_0004, 1, 32'h0000_0007, 32'hFFFF_FFF8);
        w_inst_ready = 1'b1;
        step();
        chk_wrap("wrap_resume", 1, 32'h0000_0008, 1, 32'h0000_0003, 32'hFFFF_FFFC);
        w_inst_ready = 1'b0;
        w_mem_ack = 1'b0;

        // Reset mid-WAIT with an ack arriving during and after reset.
        #2;
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        inst_ready = 1'b0;
        #1;
        chk_main("rst_async", 0, 32'h0, 0, 32'h0, 32'h0);
        step();
        chk_main("rst_hold", 0, 32'h0, 0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        chk_main("rst_first_req", 1, 32'h0, 0, 32'h0, 32'h0);
        step();
        chk_main("rst_first_word", 1, 32'h4, 1, 32'hCAFE_0001, 32'h0);
        mem_rdata = 32'hCAFE_0002;
        step();
        chk_main("depth_full", 0, 32'h4, 1, 32'hCAFE_0001, 32'h0);
        step();
        chk_main("depth_full_hold", 0, 32'h4, 1, 32'hCAFE_0001, 32'h0);
        inst_ready = 1'b1;
        step();
        chk_main("depth_resume", 1, 32'h8, 1, 32'hCAFE_0002, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
